// File: rtl/aes_mixcolumns_sequencer_if.sv
// Handshake bundle for the MixColumns sequencer.
// The input side carries the state with its mode and skip flags.
// The output side returns the result state.
// master = the round datapath that drives and consumes; slave = the sequencer.
interface aes_mixcolumns_sequencer_if;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_state;
    logic         in_enc_dec;
    logic         in_skip;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_state;

    modport master (
        output in_valid,
        output in_state,
        output in_enc_dec,
        output in_skip,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_state
    );

    modport slave (
        input  in_valid,
        input  in_state,
        input  in_enc_dec,
        input  in_skip,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_state
    );
endinterface

// File: rtl/aes_mixcolumns_sequencer.sv
// aes_mixcolumns_32bit : combinational MixColumns / InvMixColumns on one column.
// aes_mixcolumns_sequencer : walks a 128-bit state through one shared column
// unit, one column per clock. A skip path returns the state untouched for
// the final round.

module aes_mixcolumns_32bit (
    input  logic [31:0] data_in,
    input  logic        enc_dec,
    output logic [31:0] data_out
);

    // Multiply by x in GF(2^8) with the AES reduction polynomial.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] mul3(input logic [7:0] b);
        return xtime(b) ^ b;
    endfunction

    // Inverse coefficients are built from x^1..x^3 terms: 9 = 8+1,
    // 11 = 8+2+1, 13 = 8+4+1, 14 = 8+4+2.
    function automatic logic [7:0] mul9(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ b;
    endfunction

    function automatic logic [7:0] mul11(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ xtime(b) ^ b;
    endfunction

    function automatic logic [7:0] mul13(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ b;
    endfunction

    function automatic logic [7:0] mul14(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ xtime(b);
    endfunction

    logic [7:0] a0_s, a1_s, a2_s, a3_s;
    logic [7:0] o0_s, o1_s, o2_s, o3_s;

    // Split the column into bytes, byte 0 in the MSB.
    always_comb begin
        a0_s = data_in[31:24];
        a1_s = data_in[23:16];
        a2_s = data_in[15:8];
        a3_s = data_in[7:0];
    end

    // Matrix product with the forward or inverse circulant matrix.
    always_comb begin
        if (enc_dec) begin
            o0_s = xtime(a0_s) ^ mul3(a1_s)  ^ a2_s        ^ a3_s;
            o1_s = a0_s        ^ xtime(a1_s) ^ mul3(a2_s)  ^ a3_s;
            o2_s = a0_s        ^ a1_s        ^ xtime(a2_s) ^ mul3(a3_s);
            o3_s = mul3(a0_s)  ^ a1_s        ^ a2_s        ^ xtime(a3_s);
        end else begin
            o0_s = mul14(a0_s) ^ mul11(a1_s) ^ mul13(a2_s) ^ mul9(a3_s);
            o1_s = mul9(a0_s)  ^ mul14(a1_s) ^ mul11(a2_s) ^ mul13(a3_s);
            o2_s = mul13(a0_s) ^ mul9(a1_s)  ^ mul14(a2_s) ^ mul11(a3_s);
            o3_s = mul11(a0_s) ^ mul13(a1_s) ^ mul9(a2_s)  ^ mul14(a3_s);
        end
    end

    // Reassemble the output column.
    always_comb begin
        data_out = {o0_s, o1_s, o2_s, o3_s};
    end

endmodule

module aes_mixcolumns_sequencer (
    input  logic                               clk,
    input  logic                               rst_n,
    aes_mixcolumns_sequencer_if.slave          bus,
    output logic                               busy,
    output logic [1:0]                         col_idx
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t       state_r;
    state_t       state_nxt_s;
    logic [127:0] src_r;
    logic [127:0] res_r;
    logic         mode_r;
    logic [1:0]   cnt_r;
    logic         accept_s;
    logic [31:0]  col_in_s;
    logic [31:0]  col_out_s;

    // Accept only in IDLE; the reset gate keeps in_ready low while rst_n is low.
    always_comb begin
        accept_s = bus.in_valid && (state_r == ST_IDLE) && rst_n;
    end

    // Pick the source column addressed by the column counter.
    always_comb begin
        col_in_s = src_r[127:96];
        case (cnt_r)
            2'd0:    col_in_s = src_r[127:96];
            2'd1:    col_in_s = src_r[95:64];
            2'd2:    col_in_s = src_r[63:32];
            2'd3:    col_in_s = src_r[31:0];
            default: col_in_s = src_r[127:96];
        endcase
    end

    aes_mixcolumns_32bit u_mix (
        .data_in  (col_in_s),
        .enc_dec  (mode_r),
        .data_out (col_out_s)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_nxt_s = bus.in_skip ? ST_DONE : ST_RUN;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (cnt_r == 2'd3) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_DONE: begin
                if (bus.out_ready) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_DONE;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Datapath: capture on accept, write one result column per RUN cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            src_r  <= 128'h0;
            res_r  <= 128'h0;
            mode_r <= 1'b0;
            cnt_r  <= 2'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        src_r  <= bus.in_state;
                        mode_r <= bus.in_enc_dec;
                        cnt_r  <= 2'd0;
                        if (bus.in_skip) begin
                            res_r <= bus.in_state;
                        end
                    end
                end
                ST_RUN: begin
                    case (cnt_r)
                        2'd0:    res_r[127:96] <= col_out_s;
                        2'd1:    res_r[95:64]  <= col_out_s;
                        2'd2:    res_r[63:32]  <= col_out_s;
                        2'd3:    res_r[31:0]   <= col_out_s;
                        default: res_r         <= res_r;
                    endcase
                    // Natural 2-bit wrap returns the counter to 0 after column 3.
                    cnt_r <= cnt_r + 2'd1;
                end
                ST_DONE: begin
                    cnt_r <= 2'd0;
                end
                default: begin
                    cnt_r <= 2'd0;
                end
            endcase
        end
    end

    // FSM outputs, decoded from the registered state only.
    always_comb begin
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        busy          = 1'b0;
        col_idx       = 2'd0;
        case (state_r)
            ST_IDLE: begin
                bus.in_ready = rst_n;
            end
            ST_RUN: begin
                busy    = 1'b1;
                col_idx = cnt_r;
            end
            ST_DONE: begin
                busy          = 1'b1;
                bus.out_valid = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    // The result register drives out_state directly, so it stays stable in DONE and after.
    always_comb begin
        bus.out_state = res_r;
    end

endmodule
